// File: rtl/obi_wb_pkg.sv
// rtl/obi_wb_pkg.sv - shared types and constants for the OBI to Wishbone bridge
package obi_wb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WB_BUSY = 2'd1,
    RESP    = 2'd2
  } obi_wb_state_e;

  localparam logic [31:0] OBI_WB_ERR_RDATA       = 32'hDEAD_BEEF;
  localparam int unsigned OBI_WB_TIMEOUT_DEFAULT = 256;

endpackage

// File: rtl/wb_timeout_ctr.sv
// rtl/wb_timeout_ctr.sv - Wishbone wait counter, flags expiry on the CYCLES-th enabled cycle
module wb_timeout_ctr #(
  parameter int unsigned CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(CYCLES);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // The first enabled cycle sees a count of zero, so LAST marks cycle number CYCLES.
  assign expired_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/obi_to_wb.sv
// rtl/obi_to_wb.sv - OBI responder to Wishbone classic initiator, one transaction in flight
// Optional wait timeout enabled by defining OBI_TO_WB_TIMEOUT_EN.
module obi_to_wb
  import obi_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = OBI_WB_TIMEOUT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic [31:0] wbm_dat_i
);

  obi_wb_state_e state_q, state_d;
  logic          cyc_q, cyc_d;
  logic          we_q, we_d;
  logic [3:0]    sel_q, sel_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic accept;
  logic term;
  logic timeout;

  assign gnt_o    = rst_ni && ((state_q == IDLE) || (state_q == RESP));
  assign accept   = req_i && gnt_o;
  assign term     = wbm_ack_i || wbm_err_i;
  assign rvalid_o = (state_q == RESP);

  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign rdata_o   = rdata_q;
  assign err_o     = err_q;

`ifdef OBI_TO_WB_TIMEOUT_EN
  wb_timeout_ctr #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (accept),
    .en_i      (state_q == WB_BUSY),
    .expired_o (timeout)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES < 2);
  assign timeout            = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          state_d = WB_BUSY;
          cyc_d   = 1'b1;
          we_d    = we_i;
          sel_d   = be_i;
          adr_d   = addr_i;
          dat_d   = wdata_i;
        end else begin
          state_d = IDLE;
        end
      end
      WB_BUSY: begin
        // A real terminator on the expiry cycle takes precedence over the timeout.
        if (term) begin
          state_d = RESP;
          cyc_d   = 1'b0;
          err_d   = wbm_err_i;
          rdata_d = (we_q || wbm_err_i) ? 32'h0 : wbm_dat_i;
        end else if (timeout) begin
          state_d = RESP;
          cyc_d   = 1'b0;
          err_d   = 1'b1;
          rdata_d = OBI_WB_ERR_RDATA;
        end
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= 4'h0;
      adr_q   <= 32'h0;
      dat_q   <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_obi_to_wb.sv
// tb/tb_obi_to_wb.sv - directed self-checking bench for obi_to_wb
// Timeout scenario runs when OBI_TO_WB_TIMEOUT_EN is defined.
module tb_obi_to_wb;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i;
  logic        gnt_o;
  logic [31:0] addr_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic        wbm_err_i;
  logic [31:0] wbm_dat_i;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  obi_to_wb #(
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (req_i),
    .gnt_o     (gnt_o),
    .addr_i    (addr_i),
    .we_i      (we_i),
    .be_i      (be_i),
    .wdata_i   (wdata_i),
    .rvalid_o  (rvalid_o),
    .rdata_o   (rdata_o),
    .err_o     (err_o),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_ack_i (wbm_ack_i),
    .wbm_err_i (wbm_err_i),
    .wbm_dat_i (wbm_dat_i)
  );

  // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; req_i = 1'b1; addr_i = 32'h1111_2222; we_i = 1'b1; be_i = 4'hF;
    wdata_i = 32'h3333_4444; wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_dat_i = 32'h0;
    step(); step(); sample();
    checks++; if (gnt_o !== 1'b0) begin errors++; $display("FAIL rst_gnt: got %b want 0", gnt_o); end
    checks++; if (wbm_cyc_o !== 1'b0) begin errors++; $display("FAIL rst_cyc: got %b want 0", wbm_cyc_o); end
    checks++; if (wbm_stb_o !== 1'b0) begin errors++; $display("FAIL rst_stb: got %b want 0", wbm_stb_o); end
    checks++; if (wbm_we_o !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", wbm_we_o); end
    checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b want 0", rvalid_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err_o); end
    checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", rdata_o); end
    checks++; if (wbm_adr_o !== 32'h0) begin errors++; $display("FAIL rst_adr: got %h want 0", wbm_adr_o); end
    checks++; if (wbm_sel_o !== 4'h0) begin errors++; $display("FAIL rst_sel: got %h want 0", wbm_sel_o); end
    checks++; if (wbm_dat_o !== 32'h0) begin errors++; $display("FAIL rst_dat: got %h want 0", wbm_dat_o); end
    step(); rst_ni = 1'b1; req_i = 1'b0; we_i = 1'b0;
    sample();
    checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL rst_idle_gnt: got %b want 1", gnt_o); end
  endtask

  task automatic test_read_delay();
    step(); addr_i = 32'h3000_0010; we_i = 1'b0; be_i = 4'hF; req_i = 1'b1;
    sample();
    checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL rd_gnt: got %b want 1", gnt_o); end
    step(); req_i = 1'b0;
    sample();
    checks++; if ({wbm_cyc_o, wbm_stb_o, wbm_we_o} !== 3'b110) begin errors++; $display("FAIL rd_cyc1: got %b want 110", {wbm_cyc_o, wbm_stb_o, wbm_we_o}); end
    checks++; if (wbm_adr_o !== 32'h3000_0010) begin errors++; $display("FAIL rd_adr: got %h want 30000010", wbm_adr_o); end
    step(); sample();
    checks++; if ({wbm_cyc_o, rvalid_o} !== 2'b10) begin errors++; $display("FAIL rd_cyc2: got %b want 10", {wbm_cyc_o, rvalid_o}); end
    step(); wbm_ack_i = 1'b1; wbm_dat_i = 32'hCAFE_F00D;
    sample();
    checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL rd_early_rvalid: got %b want 0", rvalid_o); end
    step(); wbm_ack_i = 1'b0; wbm_dat_i = 32'h0;
    sample();
    checks++; if ({rvalid_o, err_o, wbm_cyc_o} !== 3'b100) begin errors++; $display("FAIL rd_resp: got %b want 100", {rvalid_o, err_o, wbm_cyc_o}); end
    checks++; if (rdata_o !== 32'hCAFE_F00D) begin errors++; $display("FAIL rd_rdata: got %h want cafef00d", rdata_o); end
    step(); sample();
    checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL rd_pulse: got %b want 0", rvalid_o); end
    checks++; if (rdata_o !== 32'hCAFE_F00D) begin errors++; $display("FAIL rd_hold: got %h want cafef00d", rdata_o); end
  endtask

  task automatic test_write();
    step(); addr_i = 32'h3000_0004; we_i = 1'b1; be_i = 4'b0011; wdata_i = 32'h1234_5678; req_i = 1'b1;
    sample();
    checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL wr_gnt: got %b want 1", gnt_o); end
    step(); req_i = 1'b0; we_i = 1'b0; be_i = 4'hF; wdata_i = 32'hFFFF_FFFF;
    sample();
    checks++; if ({wbm_cyc_o, wbm_we_o, wbm_sel_o} !== 6'b110011) begin errors++; $display("FAIL wr_ctl: got %b want 110011", {wbm_cyc_o, wbm_we_o, wbm_sel_o}); end
    checks++; if (wbm_dat_o !== 32'h1234_5678) begin errors++; $display("FAIL wr_dat: got %h want 12345678", wbm_dat_o); end
    step(); sample();
    checks++; if ({wbm_dat_o, wbm_sel_o} !== {32'h1234_5678, 4'b0011}) begin errors++; $display("FAIL wr_stable: got %h want 123456783", {wbm_dat_o, wbm_sel_o}); end
    wbm_ack_i = 1'b1; wbm_dat_i = 32'hAAAA_AAAA;
    step(); wbm_ack_i = 1'b0; wbm_dat_i = 32'h0;
    sample();
    checks++; if ({rvalid_o, err_o, wbm_cyc_o} !== 3'b100) begin errors++; $display("FAIL wr_resp: got %b want 100", {rvalid_o, err_o, wbm_cyc_o}); end
    checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL wr_rdata: got %h want 0", rdata_o); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [3];
    int grants = 0;
    int resps  = 0;
    a[0] = 32'h3000_0100; a[1] = 32'h3000_0104; a[2] = 32'h3000_0108;
    for (int c = 0; c < 8; c++) begin
      step();
      req_i = (grants < 3); we_i = 1'b0; be_i = 4'hF;
      addr_i = a[(grants < 3) ? grants : 2];
      wbm_ack_i = wbm_cyc_o; wbm_dat_i = wbm_adr_o ^ 32'hA5A5_0000;
      sample();
      checks++; if ((req_i && gnt_o) !== (c == 0 || c == 2 || c == 4)) begin errors++; $display("FAIL b2b_accept c%0d: got %b", c, req_i && gnt_o); end
      checks++; if (wbm_cyc_o !== (c == 1 || c == 3 || c == 5)) begin errors++; $display("FAIL b2b_cyc c%0d: got %b", c, wbm_cyc_o); end
      checks++; if (rvalid_o !== (c == 2 || c == 4 || c == 6)) begin errors++; $display("FAIL b2b_rvalid c%0d: got %b", c, rvalid_o); end
      if (rvalid_o && resps < 3) begin
        checks++; if (rdata_o !== (a[resps] ^ 32'hA5A5_0000)) begin errors++; $display("FAIL b2b_rdata %0d: got %h want %h", resps, rdata_o, a[resps] ^ 32'hA5A5_0000); end
        resps++;
      end
      if (req_i && gnt_o) grants++;
    end
    req_i = 1'b0; wbm_ack_i = 1'b0;
    checks++; if (resps !== 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", resps); end
  endtask

  task automatic test_error();
    step(); addr_i = 32'h3000_0020; we_i = 1'b0; req_i = 1'b1;
    sample();
    step(); req_i = 1'b0; wbm_ack_i = 1'b1; wbm_err_i = 1'b1; wbm_dat_i = 32'hFFFF_FFFF;
    step(); wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_dat_i = 32'h0;
    sample();
    checks++; if ({rvalid_o, err_o} !== 2'b11) begin errors++; $display("FAIL err_resp: got %b want 11", {rvalid_o, err_o}); end
    checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL err_rdata: got %h want 0", rdata_o); end
    step(); wbm_ack_i = 1'b1; wbm_dat_i = 32'h0BAD_0BAD;
    sample();
    checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL err_idle: got %b want 0", rvalid_o); end
    step(); wbm_ack_i = 1'b0; wbm_dat_i = 32'h0;
    sample();
    checks++; if ({rvalid_o, wbm_cyc_o, err_o} !== 3'b001) begin errors++; $display("FAIL spurious_ack: got %b want 001", {rvalid_o, wbm_cyc_o, err_o}); end
  endtask

  task automatic test_reset_midop();
    step(); addr_i = 32'h3000_0030; we_i = 1'b0; req_i = 1'b1;
    sample();
    step(); req_i = 1'b0;
    step(); rst_ni = 1'b0;
    sample();
    checks++; if (gnt_o !== 1'b0) begin errors++; $display("FAIL mid_gnt: got %b want 0", gnt_o); end
    step(); rst_ni = 1'b1; wbm_ack_i = 1'b1; wbm_dat_i = 32'h1111_1111;
    sample();
    checks++; if ({wbm_cyc_o, wbm_stb_o, rvalid_o} !== 3'b000) begin errors++; $display("FAIL mid_abandon: got %b want 000", {wbm_cyc_o, wbm_stb_o, rvalid_o}); end
    for (int c = 0; c < 4; c++) begin
      step(); wbm_ack_i = 1'b0;
      sample();
      checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL mid_no_resp c%0d: got %b want 0", c, rvalid_o); end
    end
    step(); addr_i = 32'h3000_0040; req_i = 1'b1;
    sample();
    checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL mid_next_gnt: got %b want 1", gnt_o); end
    step(); req_i = 1'b0; wbm_ack_i = 1'b1; wbm_dat_i = 32'h5A5A_0042;
    step(); wbm_ack_i = 1'b0; wbm_dat_i = 32'h0;
    sample();
    checks++; if ({rvalid_o, err_o} !== 2'b10) begin errors++; $display("FAIL mid_next_resp: got %b want 10", {rvalid_o, err_o}); end
    checks++; if (rdata_o !== 32'h5A5A_0042) begin errors++; $display("FAIL mid_next_rdata: got %h want 5a5a0042", rdata_o); end
    step();
  endtask

`ifdef OBI_TO_WB_TIMEOUT_EN
  task automatic test_timeout();
    step(); addr_i = 32'h3000_0050; we_i = 1'b0; req_i = 1'b1;
    sample();
    step(); req_i = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      sample();
      checks++; if ({wbm_cyc_o, rvalid_o} !== 2'b10) begin errors++; $display("FAIL to_busy c%0d: got %b want 10", c, {wbm_cyc_o, rvalid_o}); end
      step();
    end
    sample();
    checks++; if ({wbm_cyc_o, rvalid_o, err_o} !== 3'b011) begin errors++; $display("FAIL to_resp: got %b want 011", {wbm_cyc_o, rvalid_o, err_o}); end
    checks++; if (rdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL to_rdata: got %h want deadbeef", rdata_o); end
    step(); addr_i = 32'h3000_0054; req_i = 1'b1;
    sample();
    step(); req_i = 1'b0;
    for (int c = 1; c < 8; c++) step();
    wbm_ack_i = 1'b1; wbm_dat_i = 32'h7777_0008;
    step(); wbm_ack_i = 1'b0; wbm_dat_i = 32'h0;
    sample();
    checks++; if ({rvalid_o, err_o} !== 2'b10) begin errors++; $display("FAIL to_edge_resp: got %b want 10", {rvalid_o, err_o}); end
    checks++; if (rdata_o !== 32'h7777_0008) begin errors++; $display("FAIL to_edge_rdata: got %h want 77770008", rdata_o); end
    step();
  endtask
`else
  task automatic test_no_timeout();
    step(); addr_i = 32'h3000_0050; we_i = 1'b0; req_i = 1'b1;
    sample();
    step(); req_i = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      sample();
      checks++; if ({wbm_cyc_o, rvalid_o} !== 2'b10) begin errors++; $display("FAIL wait_busy c%0d: got %b want 10", c, {wbm_cyc_o, rvalid_o}); end
      step();
    end
    wbm_ack_i = 1'b1; wbm_dat_i = 32'h6666_0020;
    step(); wbm_ack_i = 1'b0; wbm_dat_i = 32'h0;
    sample();
    checks++; if ({rvalid_o, err_o} !== 2'b10) begin errors++; $display("FAIL wait_resp: got %b want 10", {rvalid_o, err_o}); end
    checks++; if (rdata_o !== 32'h6666_0020) begin errors++; $display("FAIL wait_rdata: got %h want 66660020", rdata_o); end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_read_delay();
    test_write();
    test_back_to_back();
    test_error();
    test_reset_midop();
`ifdef OBI_TO_WB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
